// File: rtl/fire_repeat_pkg.sv
// Shared types and default constants for the fire button autorepeat block.
package fire_repeat_pkg;

    localparam int unsigned DEF_TICK_DIV     = 250000;
    localparam int unsigned DEF_HOLD_TICKS   = 100;
    localparam int unsigned DEF_REPEAT_TICKS = 40;
    localparam int unsigned DEF_QUEUE_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fire_tick_gen.sv
// Timing prescaler: one-cycle tick every TICK_DIV clocks, restartable from zero.
module fire_tick_gen
    import fire_repeat_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(TICK_DIV - 1));
    assign tick   = w_last;

    always_ff @(posedge clk) begin
        if (rst || restart || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fire_repeat.sv
// Fire button autorepeat with a small pending-shot counter.
// Optional FIRE_REPEAT_STATS_EN adds a saturating dropped-shot counter on shot_drops.
module fire_repeat
    import fire_repeat_pkg::*;
#(
    parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
    parameter int unsigned HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS,
    parameter int unsigned QUEUE_DEPTH  = DEF_QUEUE_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               press_pulse,
    input  logic                               btn_level,
    input  logic                               fire_ready,
    output logic                               fire_valid,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   pending,
    output logic                               repeat_active
`ifdef FIRE_REPEAT_STATS_EN
    ,
    output logic [7:0]                         shot_drops
`endif
);

    localparam int unsigned PW   = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned MAXT = max_u(HOLD_TICKS, REPEAT_TICKS);
    localparam int unsigned TW   = $clog2(MAXT + 1);

    state_t        r_state, w_state_d;
    logic [TW-1:0] r_ticks, w_ticks_d;
    logic [PW-1:0] r_pending, w_pending_d;
    logic          r_fire_valid;
    logic          w_tick, w_enq, w_deq, w_full, w_drop;

    fire_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .restart(press_pulse),
        .tick   (w_tick)
    );

    // A fresh press always wins over release and tick expiry.
    always_comb begin
        w_state_d = r_state;
        w_ticks_d = r_ticks;
        w_enq     = 1'b0;
        if (press_pulse) begin
            w_enq     = 1'b1;
            w_state_d = HOLD;
            w_ticks_d = TW'(HOLD_TICKS);
        end else if (r_state == HOLD || r_state == REPEAT) begin
            if (!btn_level) begin
                w_state_d = IDLE;
            end else if (w_tick) begin
                if (r_ticks <= TW'(1)) begin
                    w_enq     = 1'b1;
                    w_state_d = REPEAT;
                    w_ticks_d = TW'(REPEAT_TICKS);
                end else begin
                    w_ticks_d = r_ticks - TW'(1);
                end
            end
        end
    end

    assign w_deq  = r_fire_valid && fire_ready;
    assign w_full = (r_pending == PW'(QUEUE_DEPTH));
    assign w_drop = w_enq && !w_deq && w_full;

    always_comb begin
        w_pending_d = r_pending;
        if (w_enq && !w_deq && !w_full) begin
            w_pending_d = r_pending + PW'(1);
        end else if (w_deq && !w_enq) begin
            w_pending_d = r_pending - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ticks      <= '0;
            r_pending    <= '0;
            r_fire_valid <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_ticks      <= w_ticks_d;
            r_pending    <= w_pending_d;
            r_fire_valid <= (w_pending_d != '0);
        end
    end

    assign fire_valid    = r_fire_valid;
    assign pending       = r_pending;
    assign repeat_active = (r_state == REPEAT);

`ifdef FIRE_REPEAT_STATS_EN
    logic [7:0] r_drops;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drops <= '0;
        end else if (w_drop && r_drops != 8'hFF) begin
            r_drops <= r_drops + 8'd1;
        end
    end

    assign shot_drops = r_drops;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
`endif

endmodule

// File: tb/tb_fire_repeat.sv
// Scoreboard bench for fire_repeat: expected handshake cycles are queued at press time.
module tb_fire_repeat;
    import fire_repeat_pkg::*;

    localparam int TD = 4;
    localparam int HT = 3;
    localparam int RT = 2;
    localparam int QD = 2;

    logic       clk;
    logic       rst;
    logic       press_pulse;
    logic       btn_level;
    logic       fire_ready;
    logic       fire_valid;
    logic [1:0] pending;
    logic       repeat_active;
`ifdef FIRE_REPEAT_STATS_EN
    logic [7:0] shot_drops;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_q[$];

    fire_repeat #(
        .TICK_DIV    (TD),
        .HOLD_TICKS  (HT),
        .REPEAT_TICKS(RT),
        .QUEUE_DEPTH (QD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .press_pulse  (press_pulse),
        .btn_level    (btn_level),
        .fire_ready   (fire_ready),
        .fire_valid   (fire_valid),
        .pending      (pending),
        .repeat_active(repeat_active)
`ifdef FIRE_REPEAT_STATS_EN
        ,
        .shot_drops   (shot_drops)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        press_pulse = 1'b0;
        btn_level   = 1'b0;
        fire_ready  = 1'b1;
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        press_pulse = 1'b1;
        btn_level   = 1'b1;
        fire_ready  = 1'b0;
        step();
        step();
        n_cmp++;
        if (pending !== 2'd0) begin
            n_fail++; $display("FAIL reset_pending: got %0d want 0", pending);
        end
        n_cmp++;
        if (fire_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", fire_valid);
        end
        n_cmp++;
        if (repeat_active !== 1'b0) begin
            n_fail++; $display("FAIL reset_repeat: got %b want 0", repeat_active);
        end
        n_cmp++;
        if (dut.r_state !== IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.r_state, IDLE);
        end
        rst         = 1'b0;
        press_pulse = 1'b0;
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (pending !== 2'd0) begin
            n_fail++; $display("FAIL reset_press_ignored: pending %0d want 0", pending);
        end
    endtask

    task automatic test_tap();
        int e;
        for (int t = 0; t <= 10; t++) begin
            n_cmp++;
            if (fire_valid !== (t == 1)) begin
                n_fail++; $display("FAIL tap_valid: cycle %0d got %b want %b", t, fire_valid, t == 1);
            end
            if (t == 6) begin
                n_cmp++;
                if (dut.r_state !== HOLD) begin
                    n_fail++; $display("FAIL tap_hold: cycle 6 state %0d want %0d", dut.r_state, HOLD);
                end
            end
            if (t == 7) begin
                n_cmp++;
                if (dut.r_state !== IDLE) begin
                    n_fail++; $display("FAIL tap_idle: cycle 7 state %0d want %0d", dut.r_state, IDLE);
                end
            end
            press_pulse = (t == 0);
            btn_level   = (t <= 5);
            fire_ready  = 1'b1;
            if (t == 0) exp_q.push_back(1);
            if (fire_valid && fire_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL tap_shot: unexpected shot at cycle %0d", t);
                end else begin
                    e = exp_q.pop_front();
                    if (t !== e) begin
                        n_fail++; $display("FAIL tap_shot: shot at cycle %0d want %0d", t, e);
                    end
                end
            end
            step();
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL tap_left: %0d shots missing want 0", exp_q.size());
        end
    endtask

    task automatic test_hold();
        int e;
        for (int t = 0; t <= 48; t++) begin
            n_cmp++;
            if (repeat_active !== (t >= 13 && t <= 40)) begin
                n_fail++; $display("FAIL hold_repeat: cycle %0d got %b", t, repeat_active);
            end
            if (t == 41) begin
                n_cmp++;
                if (dut.r_state !== IDLE) begin
                    n_fail++; $display("FAIL hold_idle: cycle 41 state %0d want %0d", dut.r_state, IDLE);
                end
            end
            press_pulse = (t == 0);
            btn_level   = (t <= 39);
            fire_ready  = 1'b1;
            if (t == 0) begin
                exp_q.push_back(1);
                for (int c = HT * TD; c < 40; c += RT * TD) exp_q.push_back(c + 1);
            end
            if (fire_valid && fire_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL hold_shot: unexpected shot at cycle %0d", t);
                end else begin
                    e = exp_q.pop_front();
                    if (t !== e) begin
                        n_fail++; $display("FAIL hold_shot: shot at cycle %0d want %0d", t, e);
                    end
                end
            end
            step();
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL hold_left: %0d shots missing want 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int e;
        int want;
        for (int t = 0; t <= 36; t++) begin
            want = -1;
            case (t)
                1:  want = 1;
                13: want = 2;
                21: want = 2;
                29: want = 2;
                32: want = 1;
                33: want = 0;
                default: want = -1;
            endcase
            if (want >= 0) begin
                n_cmp++;
                if (int'(pending) !== want) begin
                    n_fail++; $display("FAIL bp_pending: cycle %0d got %0d want %0d", t, pending, want);
                end
            end
`ifdef FIRE_REPEAT_STATS_EN
            if (t == 30) begin
                n_cmp++;
                if (shot_drops !== 8'd2) begin
                    n_fail++; $display("FAIL bp_drops: got %0d want 2", shot_drops);
                end
            end
`endif
            press_pulse = (t == 0);
            btn_level   = (t <= 29);
            fire_ready  = (t >= 31);
            if (t == 0) begin
                exp_q.push_back(31);
                exp_q.push_back(32);
            end
            if (fire_valid && fire_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_shot: unexpected shot at cycle %0d", t);
                end else begin
                    e = exp_q.pop_front();
                    if (t !== e) begin
                        n_fail++; $display("FAIL bp_shot: shot at cycle %0d want %0d", t, e);
                    end
                end
            end
            step();
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL bp_left: %0d shots missing want 0", exp_q.size());
        end
    endtask

    task automatic test_full_simultaneous();
        int e;
        int want;
        for (int t = 0; t <= 28; t++) begin
            want = -1;
            case (t)
                20: want = 2;
                21: want = 2;
                26: want = 0;
                default: want = -1;
            endcase
            if (want >= 0) begin
                n_cmp++;
                if (int'(pending) !== want) begin
                    n_fail++; $display("FAIL full_pending: cycle %0d got %0d want %0d", t, pending, want);
                end
            end
`ifdef FIRE_REPEAT_STATS_EN
            if (t == 22) begin
                n_cmp++;
                if (shot_drops !== 8'd0) begin
                    n_fail++; $display("FAIL full_drops: got %0d want 0", shot_drops);
                end
            end
`endif
            press_pulse = (t == 0);
            btn_level   = (t <= 20);
            fire_ready  = (t == 20) || (t >= 24);
            if (t == 0) begin
                exp_q.push_back(20);
                exp_q.push_back(24);
                exp_q.push_back(25);
            end
            if (fire_valid && fire_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL full_shot: unexpected shot at cycle %0d", t);
                end else begin
                    e = exp_q.pop_front();
                    if (t !== e) begin
                        n_fail++; $display("FAIL full_shot: shot at cycle %0d want %0d", t, e);
                    end
                end
            end
            step();
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL full_left: %0d shots missing want 0", exp_q.size());
        end
    endtask

    task automatic test_repress();
        int e;
        logic want_rep;
        for (int t = 0; t <= 50; t++) begin
            want_rep = (t >= 13 && t <= 22) || (t >= 35 && t <= 45);
            n_cmp++;
            if (repeat_active !== want_rep) begin
                n_fail++; $display("FAIL repress_repeat: cycle %0d got %b want %b", t, repeat_active, want_rep);
            end
            press_pulse = (t == 0) || (t == 22);
            btn_level   = (t <= 44);
            fire_ready  = 1'b1;
            if (t == 0) begin
                exp_q.push_back(1);
                exp_q.push_back(1 + HT * TD);
                exp_q.push_back(1 + HT * TD + RT * TD);
            end
            if (t == 22) begin
                exp_q.push_back(23);
                exp_q.push_back(23 + HT * TD);
                exp_q.push_back(23 + HT * TD + RT * TD);
            end
            if (fire_valid && fire_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL repress_shot: unexpected shot at cycle %0d", t);
                end else begin
                    e = exp_q.pop_front();
                    if (t !== e) begin
                        n_fail++; $display("FAIL repress_shot: shot at cycle %0d want %0d", t, e);
                    end
                end
            end
            step();
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL repress_left: %0d shots missing want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_repeat();
        int e;
        for (int t = 0; t <= 42; t++) begin
            if (t == 25) begin
                n_cmp++;
                if (pending !== 2'd1 || repeat_active !== 1'b1) begin
                    n_fail++; $display("FAIL midrst_pre: pending %0d repeat %b want 1 1", pending, repeat_active);
                end
            end
            if (t == 26) begin
                n_cmp++;
                if (pending !== 2'd0) begin
                    n_fail++; $display("FAIL midrst_pending: got %0d want 0", pending);
                end
                n_cmp++;
                if (fire_valid !== 1'b0) begin
                    n_fail++; $display("FAIL midrst_valid: got %b want 0", fire_valid);
                end
                n_cmp++;
                if (dut.r_state !== IDLE || repeat_active !== 1'b0) begin
                    n_fail++; $display("FAIL midrst_state: state %0d repeat %b want %0d 0", dut.r_state, repeat_active, IDLE);
                end
            end
            if (t == 42) begin
                n_cmp++;
                if (pending !== 2'd0) begin
                    n_fail++; $display("FAIL midrst_after: pending %0d want 0", pending);
                end
            end
            rst         = (t == 25);
            press_pulse = (t == 0) || (t == 25);
            btn_level   = (t <= 40);
            fire_ready  = (t <= 20) || (t >= 26);
            if (t == 0) begin
                exp_q.push_back(1);
                exp_q.push_back(1 + HT * TD);
            end
            if (fire_valid && fire_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL midrst_shot: unexpected shot at cycle %0d", t);
                end else begin
                    e = exp_q.pop_front();
                    if (t !== e) begin
                        n_fail++; $display("FAIL midrst_shot: shot at cycle %0d want %0d", t, e);
                    end
                end
            end
            step();
        end
        rst = 1'b0;
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL midrst_left: %0d shots missing want 0", exp_q.size());
        end
    endtask

    initial begin
        rst         = 1'b1;
        press_pulse = 1'b0;
        btn_level   = 1'b0;
        fire_ready  = 1'b0;
        test_reset();
        do_reset();
        test_tap();
        do_reset();
        test_hold();
        do_reset();
        test_backpressure();
        do_reset();
        test_full_simultaneous();
        do_reset();
        test_repress();
        do_reset();
        test_reset_mid_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fire_repeat.md
FIRE_REPEAT -- requirements
Module: fire_repeat

Interface
REQ-001 SHALL have parameter TICK_DIV, default 250000, clk cycles per timing tick (400 Hz at 100 MHz).
REQ-002 SHALL have parameter HOLD_TICKS, default 100, ticks a held button waits before autorepeat starts.
REQ-003 SHALL have parameter REPEAT_TICKS, default 40, ticks between autorepeat shots.
REQ-004 SHALL have parameter QUEUE_DEPTH, default 4, maximum pending shots (>=1).
REQ-005 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port press_pulse  input  1  single-cycle clean press event from the button debouncer.
REQ-008 SHALL have port btn_level  input  1  synchronised held state of the same button (1 = held).
REQ-009 SHALL have port fire_ready  input  1  game engine accepts a shot this cycle.
REQ-010 SHALL have port fire_valid  output  1  at least one shot pending.
REQ-011 SHALL have port pending  output  $clog2(QUEUE_DEPTH+1)  count of queued shots.
REQ-012 SHALL have port repeat_active  output  1  high while FSM is in REPEAT.

Function
REQ-013 SHALL implement FSM states IDLE, HOLD, REPEAT.
REQ-014 Any state, press_pulse=1: enqueue one shot, enter HOLD, load hold counter with HOLD_TICKS, restart prescaler to 0.
REQ-015 HOLD: decrement hold counter per tick; on reaching 0 enqueue one shot, enter REPEAT, load REPEAT_TICKS.
REQ-016 REPEAT: decrement per tick; on reaching 0 enqueue one shot, reload REPEAT_TICKS.
REQ-017 HOLD or REPEAT with btn_level=0 and press_pulse=0: enter IDLE next cycle, no enqueue that cycle.
REQ-018 Tick: prescaler counts 0..TICK_DIV-1, tick asserted on cycle counter==TICK_DIV-1, counter wraps to 0.
REQ-019 Hold shot SHALL be enqueued exactly HOLD_TICKS*TICK_DIV cycles after the press_pulse cycle; repeats every REPEAT_TICKS*TICK_DIV cycles thereafter.
REQ-020 fire_valid SHALL equal (pending != 0), registered; enqueue at cycle N visible at N+1.
REQ-021 Dequeue SHALL occur when fire_valid && fire_ready; pending decrements by 1.
REQ-022 Simultaneous enqueue and dequeue SHALL leave pending unchanged, including when pending==QUEUE_DEPTH.
REQ-023 Enqueue with pending==QUEUE_DEPTH and no dequeue SHALL drop the shot; pending saturates.
REQ-024 fire_ready while fire_valid=0 SHALL be ignored; pending never underflows.

Reset
REQ-025 rst=1 SHALL force state IDLE, pending=0, fire_valid=0, repeat_active=0, prescaler and tick counters 0, on next edge.
REQ-026 rst asserted mid-HOLD/REPEAT SHALL discard queued shots; press_pulse during rst ignored.

Configuration
REQ-027 With FIRE_REPEAT_STATS_EN defined, SHALL add output shot_drops [7:0], count of dropped shots (REQ-023), saturating at 255, cleared by rst.
REQ-028 Without FIRE_REPEAT_STATS_EN, port shot_drops and its counter SHALL not exist; all other behaviour identical.

Structure
REQ-029 Package fire_repeat_pkg SHALL hold the state enum (IDLE, HOLD, REPEAT) and default constants for TICK_DIV, HOLD_TICKS, REPEAT_TICKS, QUEUE_DEPTH.
REQ-030 Prescaler SHALL be sub-module fire_tick_gen (ports clk, rst, restart, tick; parameter TICK_DIV).

Verification (TICK_DIV=4, HOLD_TICKS=3, REPEAT_TICKS=2, QUEUE_DEPTH=2, fire_ready=1 unless stated)
REQ-031 Tap: press_pulse at cycle 0, btn_level high cycles 0-5 -> fire_valid high cycle 1 only, one handshake, state IDLE by cycle 7.
REQ-032 Hold: press at 0, btn_level held to 40 -> shots enqueued cycles 0,12,20,28,36; repeat_active high from cycle 13; IDLE at 41.
REQ-033 Backpressure: fire_ready=0, hold to 30 -> pending 1,2,2 at cycles 1,13,21; 2 shots dropped (shot_drops=2 with STATS_EN at cycle 30); fire_ready=1 at 31 -> pending 1 at 32, 0 at 33.
REQ-034 Full+simultaneous: pending=2, fire_ready=1 on repeat-enqueue cycle -> pending stays 2 next cycle, no drop counted.
REQ-035 Re-press in REPEAT: second press_pulse at cycle 22 -> enqueue at 22, HOLD re-entered, next auto shot at cycle 34, repeat_active low 23-34.
REQ-036 Reset mid-REPEAT: rst at cycle 25 with pending=1 -> cycle 26 pending=0, fire_valid=0, state IDLE; no shots until next press_pulse.
